// File: rtl/sobel_pkg.sv
// sobel_pkg: types and default constants shared by the Sobel datapath blocks.
package sobel_pkg;

   localparam int unsigned DEF_WR_STARVE_LIMIT = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES  = 255;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_READ  = 2'd1,
      ARB_WRITE = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: loadable down-counter with a terminal-count flag at zero.
module flex_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             count_en,
   output logic             term_cnt
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count_en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign term_cnt = (count == '0);

endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one SRAM port between pixel-fetch reads and edge-buffer writes.
// Define ARB_TIMEOUT_EN to abort accesses whose sram_ready never arrives.
//
// state     | meaning
// ARB_IDLE  | no access in flight; arbitrate rd_req / wr_req
// ARB_READ  | sram_read_en high, waiting for sram_ready
// ARB_WRITE | sram_write_en high, waiting for sram_ready
// ARB_DONE  | one-cycle done pulse for the served requester
module sram_access_arbiter
   import sobel_pkg::*;
#(
   parameter int unsigned WR_STARVE_LIMIT = DEF_WR_STARVE_LIMIT,
   parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   output logic [31:0] rd_data,
   output logic        rd_done,
   input  logic        wr_req,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic        wr_done,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        sram_read_en,
   output logic        sram_write_en,
   input  logic        sram_ready,
   output logic        arb_err
);

   localparam int unsigned SW = (WR_STARVE_LIMIT > 0) ? $clog2(WR_STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE_LIMIT);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [SW-1:0] starve_cnt;
   logic          serve_wr;
   logic          grant_rd;
   logic          grant_wr;
   logic          strobe;
   logic          timeout;

   assign strobe   = (state == ARB_READ) || (state == ARB_WRITE);
   // writes win a tie only once the read streak has hit the starvation limit
   assign grant_wr = (state == ARB_IDLE) && wr_req && (!rd_req || (starve_cnt == STARVE_MAX));
   assign grant_rd = (state == ARB_IDLE) && rd_req && !grant_wr;

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (grant_rd) begin
               state_nxt = ARB_READ;
            end else if (grant_wr) begin
               state_nxt = ARB_WRITE;
            end
         end
         ARB_READ, ARB_WRITE: begin
            if (sram_ready) begin
               state_nxt = ARB_DONE;
            end else if (timeout) begin
               state_nxt = ARB_IDLE;
            end
         end
         ARB_DONE: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ARB_IDLE;
         starve_cnt <= '0;
         serve_wr   <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rd_data    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_rd) begin
            sram_addr <= rd_addr;
            serve_wr  <= 1'b0;
            if (wr_req && (starve_cnt != STARVE_MAX)) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end
         if (grant_wr) begin
            sram_addr  <= wr_addr;
            sram_wdata <= wr_data;
            serve_wr   <= 1'b1;
            starve_cnt <= '0;
         end
         if ((state == ARB_READ) && sram_ready) begin
            rd_data <= sram_rdata;
         end
      end
   end

   assign sram_read_en  = (state == ARB_READ);
   assign sram_write_en = (state == ARB_WRITE);
   assign rd_done       = (state == ARB_DONE) && !serve_wr;
   assign wr_done       = (state == ARB_DONE) && serve_wr;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic wait_tc;
   logic arb_err_q;

   // loaded at grant so it reads zero during the last permitted strobe cycle
   flex_counter #(
      .WIDTH (TW)
   ) u_wait_cnt (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (grant_rd || grant_wr),
      .load_val (TW'(TIMEOUT_CYCLES - 1)),
      .count_en (strobe),
      .term_cnt (wait_tc)
   );

   assign timeout = strobe && wait_tc && !sram_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         arb_err_q <= 1'b0;
      end else begin
         arb_err_q <= timeout;
      end
   end

   assign arb_err = arb_err_q;
`else
   assign timeout = 1'b0;
   assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_sram_access_arbiter;

   localparam int unsigned LIMIT = 4;
   localparam int unsigned TMO   = 255;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        rd_done;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_done;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_read_en;
   logic        sram_write_en;
   logic        sram_ready;
   logic        arb_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_access_arbiter #(
      .WR_STARVE_LIMIT (LIMIT),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_done       (rd_done),
      .wr_req        (wr_req),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_done       (wr_done),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata),
      .sram_read_en  (sram_read_en),
      .sram_write_en (sram_write_en),
      .sram_ready    (sram_ready),
      .arb_err       (arb_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; sram_ready = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; sram_rdata = '0;
      #3;
      n_checks++;
      if ({sram_read_en, sram_write_en, rd_done, wr_done, arb_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl got=%b exp=00000", {sram_read_en, sram_write_en, rd_done, wr_done, arb_err});
      end
      n_checks++;
      if ({rd_data, sram_addr, sram_wdata} !== 96'b0) begin
         n_fail++;
         $display("FAIL reset_data got=%h exp=0", {rd_data, sram_addr, sram_wdata});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      tick();
      n_checks++;
      if ({sram_read_en, sram_write_en, rd_done, wr_done} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_release got=%b exp=0000", {sram_read_en, sram_write_en, rd_done, wr_done});
      end
   endtask

   task automatic test_read_basic();
      int strobes;
      int cyc_done;
      logic [31:0] got;
      strobes = 0; cyc_done = -1; got = '0;
      tick();
      rd_req = 1'b1; rd_addr = 32'h100; sram_rdata = 32'hDEAD_BEEF; sram_ready = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (sram_read_en) begin
            strobes++;
            if (strobes == 2) sram_ready = 1'b1;
            n_checks++;
            if (sram_addr !== 32'h100 || sram_write_en !== 1'b0) begin
               n_fail++;
               $display("FAIL rd_strobe addr=%h wen=%b exp addr=100 wen=0", sram_addr, sram_write_en);
            end
         end
         if (rd_done) begin
            cyc_done = c; got = rd_data;
            rd_req = 1'b0; sram_ready = 1'b0;
            break;
         end
      end
      n_checks++;
      if (strobes != 2 || cyc_done != 3) begin
         n_fail++;
         $display("FAIL rd_latency strobes=%0d done_cycle=%0d exp 2 and 3", strobes, cyc_done);
      end
      n_checks++;
      if (got !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL rd_data got=%h exp=deadbeef", got);
      end
      tick();
      n_checks++;
      if (rd_done !== 1'b0 || sram_read_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_after done=%b ren=%b exp 0 0", rd_done, sram_read_en);
      end
   endtask

   task automatic test_write_basic();
      int strobes;
      int cyc_done;
      int rd_pulses;
      strobes = 0; cyc_done = -1; rd_pulses = 0;
      tick();
      wr_req = 1'b1; wr_addr = 32'h2000; wr_data = 32'hFFFF_0000; sram_ready = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (rd_done) rd_pulses++;
         if (sram_write_en) begin
            strobes++;
            n_checks++;
            if (sram_addr !== 32'h2000 || sram_wdata !== 32'hFFFF_0000 || sram_read_en !== 1'b0) begin
               n_fail++;
               $display("FAIL wr_strobe addr=%h wdata=%h ren=%b exp 2000 ffff0000 0", sram_addr, sram_wdata, sram_read_en);
            end
         end
         if (wr_done) begin
            cyc_done = c;
            wr_req = 1'b0; sram_ready = 1'b0;
            break;
         end
      end
      n_checks++;
      if (strobes != 1 || cyc_done != 2 || rd_pulses != 0) begin
         n_fail++;
         $display("FAIL wr_latency strobes=%0d done_cycle=%0d rd_pulses=%0d exp 1 2 0", strobes, cyc_done, rd_pulses);
      end
   endtask

   task automatic test_starvation();
      int grants;
      tick();
      grants = 0;
      rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'h10; wr_addr = 32'h20; sram_ready = 1'b1;
      for (int c = 0; c < 100 && grants < 15; c++) begin
         tick();
         if (sram_read_en || sram_write_en) begin
            n_checks++;
            if (sram_write_en !== ((grants % (LIMIT + 1)) == LIMIT) || (sram_read_en && sram_write_en)) begin
               n_fail++;
               $display("FAIL starve_grant idx=%0d ren=%b wen=%b exp_write=%0d", grants, sram_read_en,
                        sram_write_en, ((grants % (LIMIT + 1)) == LIMIT));
            end
            grants++;
         end
      end
      n_checks++;
      if (grants != 15) begin
         n_fail++;
         $display("FAIL starve_count got=%0d exp=15", grants);
      end
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (3) tick();
      sram_ready = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      int bad;
      bad = 0;
      tick();
      wr_req = 1'b1; wr_addr = 32'h3000; wr_data = 32'h1234_5678; sram_ready = 1'b0;
      tick();
      n_checks++;
      if (sram_write_en !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre wen=%b exp=1", sram_write_en);
      end
      #2 n_rst = 1'b0;
      #1;
      n_checks++;
      if ({sram_read_en, sram_write_en, rd_done, wr_done, arb_err} !== 5'b0 ||
          {rd_data, sram_addr, sram_wdata} !== 96'b0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs ctrl=%b data=%h exp all 0",
                  {sram_read_en, sram_write_en, rd_done, wr_done, arb_err}, {rd_data, sram_addr, sram_wdata});
      end
      wr_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (4) begin
         tick();
         if (wr_done || sram_write_en || sram_read_en) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rst_mid_nodone got=%0d busy cycles exp=0", bad);
      end
      rd_req = 1'b1; rd_addr = 32'h44; sram_ready = 1'b1;
      tick();
      n_checks++;
      if (sram_read_en !== 1'b1 || sram_addr !== 32'h44) begin
         n_fail++;
         $display("FAIL rst_mid_regrant ren=%b addr=%h exp 1 44", sram_read_en, sram_addr);
      end
      rd_req = 1'b0;
      tick();
      sram_ready = 1'b0;
      tick();
   endtask

   task automatic test_rd_drop();
      int pulses;
      logic [31:0] got;
      pulses = 0; got = '0;
      tick();
      rd_req = 1'b1; rd_addr = 32'h500; sram_rdata = 32'hCAFE_F00D; sram_ready = 1'b0;
      tick();
      n_checks++;
      if (sram_read_en !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_first ren=%b exp=1", sram_read_en);
      end
      rd_req = 1'b0;
      tick();
      n_checks++;
      if (sram_read_en !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_hold ren=%b exp=1", sram_read_en);
      end
      sram_ready = 1'b1;
      repeat (6) begin
         tick();
         sram_ready = 1'b0;
         if (rd_done) begin
            pulses++;
            got = rd_data;
         end
      end
      n_checks++;
      if (pulses != 1 || got !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL drop_done pulses=%0d data=%h exp 1 cafef00d", pulses, got);
      end
   endtask

   // Transaction-level reference: one access at a time, reads favoured until
   // LIMIT consecutive reads have been granted over a waiting write.
   task automatic test_random();
      int          m_acc;
      int          m_fin;
      int unsigned m_starve;
      logic [31:0] m_addr;
      logic [31:0] m_wdata;
      logic [31:0] m_rdata;
      bit          rd_act;
      bit          wr_act;
      m_acc = 0; m_fin = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      rd_act = 1'b0; wr_act = 1'b0;
      @(negedge clk);
      n_rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; sram_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         n_checks++;
         if ({sram_read_en, sram_write_en} !== {m_acc == 1, m_acc == 2}) begin
            n_fail++;
            $display("FAIL rnd_strobe cyc=%0d got=%b exp=%b", cyc, {sram_read_en, sram_write_en}, {m_acc == 1, m_acc == 2});
         end
         n_checks++;
         if (sram_addr !== m_addr) begin
            n_fail++;
            $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, sram_addr, m_addr);
         end
         n_checks++;
         if (sram_wdata !== m_wdata) begin
            n_fail++;
            $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, sram_wdata, m_wdata);
         end
         n_checks++;
         if ({rd_done, wr_done, arb_err} !== {m_fin == 1, m_fin == 2, 1'b0}) begin
            n_fail++;
            $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, {rd_done, wr_done, arb_err}, {m_fin == 1, m_fin == 2, 1'b0});
         end
         n_checks++;
         if (rd_data !== m_rdata) begin
            n_fail++;
            $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rd_data, m_rdata);
         end
         if (m_fin == 1) rd_act = 1'b0;
         if (m_fin == 2) wr_act = 1'b0;
         if (!rd_act && $urandom_range(0, 2) == 0) begin
            rd_act = 1'b1; rd_addr = $urandom;
         end
         if (!wr_act && $urandom_range(0, 2) == 0) begin
            wr_act = 1'b1; wr_addr = $urandom; wr_data = $urandom;
         end
         rd_req = rd_act; wr_req = wr_act;
         sram_ready = ($urandom_range(0, 2) == 0);
         sram_rdata = $urandom;
         if (m_fin != 0) begin
            m_fin = 0;
         end else if (m_acc != 0) begin
            if (sram_ready) begin
               if (m_acc == 1) m_rdata = sram_rdata;
               m_fin = m_acc;
               m_acc = 0;
            end
         end else if (wr_req && (!rd_req || m_starve == LIMIT)) begin
            m_acc = 2; m_addr = wr_addr; m_wdata = wr_data; m_starve = 0;
         end else if (rd_req) begin
            m_acc = 1; m_addr = rd_addr;
            if (wr_req && m_starve < LIMIT) m_starve++;
         end
      end
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0; sram_ready = 1'b1;
      repeat (4) @(negedge clk);
      sram_ready = 1'b0;
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int strobes;
      int dones;
      strobes = 0; dones = 0;
      tick();
      wr_req = 1'b1; wr_addr = 32'h7000; wr_data = 32'h55AA_55AA; sram_ready = 1'b0;
      for (int c = 0; c < 400; c++) begin
         tick();
         if (sram_write_en) begin
            strobes++;
         end else if (strobes > 0) begin
            break;
         end
      end
      n_checks++;
      if (strobes != TMO || arb_err !== 1'b1 || wr_done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_abort strobes=%0d err=%b done=%b exp %0d 1 0", strobes, arb_err, wr_done, TMO);
      end
      wr_req = 1'b0;
      repeat (3) begin
         tick();
         if (wr_done || rd_done || arb_err) dones++;
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL timeout_quiet got=%0d pulses exp=0", dones);
      end
      rd_req = 1'b1; rd_addr = 32'h900; sram_rdata = 32'h0BAD_CAFE; sram_ready = 1'b1;
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (rd_done) begin
            dones++;
            rd_req = 1'b0;
         end
      end
      sram_ready = 1'b0;
      n_checks++;
      if (dones != 1 || rd_data !== 32'h0BAD_CAFE) begin
         n_fail++;
         $display("FAIL timeout_recover pulses=%0d data=%h exp 1 0badcafe", dones, rd_data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_read_basic();
      test_write_basic();
      test_starvation();
      test_reset_mid_write();
      test_rd_drop();
      test_random();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
